// File: rtl/audio_sample_sequencer_pkg.sv
// Shared definitions for the audio sample sequencer: default widths, FSM state
// encoding and the hold-counter width helper.
package audio_seq_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        HOLD = ST_HOLD
    } seq_state_e;

    // Bits needed to count 0 .. cycles-1, never less than one.
    function automatic int hold_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/audio_sample_sequencer_if.sv
// Sample-in / memory-interface bus of the audio sample sequencer.
// master = sequencer side, slave = source / memory side.
interface audio_sample_sequencer_if
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              mem_status;
    logic [DATA_W-1:0] mem_read_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;

    modport master (
        input  sample_in, sample_valid, mem_status, mem_read_out,
        output addr_out, data_out
    );

    modport slave (
        output sample_in, sample_valid, mem_status, mem_read_out,
        input  addr_out, data_out
    );
endinterface

// File: rtl/audio_sample_sequencer_fifo.sv
// sample_fifo: synchronous FIFO with flush; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW:0]       count_r;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array, written on accepted pushes only.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLK) begin
        if (!reset || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/audio_sample_sequencer.sv
// Buffers audio samples and presents them with sequential RAM addresses to the
// DDR2 memory interface. Optional readback check: AUDIO_SEQ_READBACK_VERIFY_EN.
module audio_sample_sequencer
    import audio_seq_pkg::*;
#(
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              FIFO_DEPTH  = 8,
    parameter int              HOLD_CYCLES = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}}
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      rec_start,
    input  logic                      rec_enable,
    audio_sample_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]         rec_length,
    output logic                      busy,
    output logic                      full,
    output logic                      overflow,
    output logic [7:0]                err_count
);
    localparam int            CW        = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    seq_state_e        state_r;
    logic [CW-1:0]     hold_cnt_r;
    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] rec_length_r;
    logic              full_r;
    logic              overflow_r;

    logic                       push_req_s;
    logic                       pop_s;
    logic                       commit_s;
    logic                       drop_s;
    logic [DATA_W-1:0]          fifo_dout_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;

    // Push/pop/commit qualification for the current cycle.
    always_comb begin
        push_req_s = bus.sample_valid && rec_enable && !full_r;
        pop_s      = (state_r == IDLE) && !fifo_empty_s && !full_r;
        commit_s   = (state_r == HOLD) && bus.mem_status && (hold_cnt_r == HOLD_LAST);
        drop_s     = push_req_s && fifo_full_s && !pop_s;
    end

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .flush (rec_start),
        .push  (push_req_s),
        .pop   (pop_s),
        .din   (bus.sample_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Sequencer FSM: pop -> one LOAD cycle -> HOLD until enough ready cycles.
    always_ff @(posedge CLK) begin
        if (!reset || rec_start) begin
            state_r      <= IDLE;
            hold_cnt_r   <= {CW{1'b0}};
            wptr_r       <= {ADDR_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            rec_length_r <= {ADDR_W{1'b0}};
            full_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (drop_s) overflow_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        data_r  <= fifo_dout_s;
                        addr_r  <= wptr_r;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    hold_cnt_r <= {CW{1'b0}};
                    state_r    <= HOLD;
                end
                HOLD: begin
                    if (commit_s) begin
                        rec_length_r <= wptr_r + ADDR_ONE;
                        if (wptr_r == MAX_ADDR) full_r <= 1'b1;
                        else                    wptr_r <= wptr_r + ADDR_ONE;
                        state_r <= IDLE;
                    end else if (bus.mem_status) begin
                        hold_cnt_r <= hold_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef AUDIO_SEQ_READBACK_VERIFY_EN
    logic [7:0] err_r;

    // Saturating count of readback values that differ from the written sample.
    always_ff @(posedge CLK) begin
        if (!reset || rec_start) begin
            err_r <= 8'h00;
        end else if (commit_s && (bus.mem_read_out != data_r) && (err_r != 8'hFF)) begin
            err_r <= err_r + 8'h01;
        end
    end

    assign err_count = err_r;
`else
    logic unused_rb_s;
    assign unused_rb_s = ^bus.mem_read_out;
    assign err_count   = 8'h00;
`endif

    assign bus.addr_out = addr_r;
    assign bus.data_out = data_r;
    assign rec_length   = rec_length_r;
    assign full         = full_r;
    assign overflow     = overflow_r;
    assign busy         = (state_r != IDLE) || (fifo_count_s != {($clog2(FIFO_DEPTH)+1){1'b0}});
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_audio_sample_sequencer;
    localparam int          AW    = 26;
    localparam int          DW    = 16;
    localparam int          DEPTH = 8;
    localparam int          HOLD  = 16;
    localparam logic [25:0] MAXA  = 26'd12;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        rec_start = 1'b0;
    logic        rec_enable = 1'b0;
    logic [25:0] rec_length;
    logic        busy, full, overflow;
    logic [7:0]  err_count;

    audio_sample_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    audio_sample_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .MAX_ADDR(MAXA)
    ) dut (
        .CLK(CLK), .reset(reset), .rec_start(rec_start), .rec_enable(rec_enable),
        .bus(bus), .rec_length(rec_length), .busy(busy), .full(full),
        .overflow(overflow), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rb_flip = 1'b0;

    // Model state: queue of buffered samples, one in-flight write, flags.
    logic [15:0] q[$];
    bit          m_active = 1'b0;
    bit          m_load = 1'b0;
    int          m_need = 0;
    logic [25:0] m_wptr = 26'd0, m_addr = 26'd0, m_len = 26'd0;
    logic [15:0] m_data = 16'd0;
    bit          m_full = 1'b0, m_ovf = 1'b0;
    int          m_err = 0;

    // Memory returns what was written, optionally with bit 0 corrupted.
    assign bus.mem_read_out = m_data ^ {15'd0, rb_flip};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced once per clock edge.
    always @(posedge CLK) begin : model
        bit do_pop, push_req;
        int old_size;
        if (!reset || rec_start) begin
            q.delete();
            m_active = 1'b0; m_load = 1'b0; m_need = 0;
            m_wptr = 26'd0; m_addr = 26'd0; m_len = 26'd0; m_data = 16'd0;
            m_full = 1'b0; m_ovf = 1'b0; m_err = 0;
        end else begin
            old_size = q.size();
            do_pop   = !m_active && (old_size > 0) && !m_full;
            push_req = bus.sample_valid && rec_enable && !m_full;
            if (m_active) begin
                if (m_load) m_load = 1'b0;
                else if (bus.mem_status) begin
                    m_need--;
                    if (m_need == 0) begin
                        m_len = m_wptr + 26'd1;
`ifdef AUDIO_SEQ_READBACK_VERIFY_EN
                        if (bus.mem_read_out != m_data && m_err < 255) m_err++;
`endif
                        if (m_wptr == MAXA) m_full = 1'b1;
                        else                m_wptr = m_wptr + 26'd1;
                        m_active = 1'b0;
                    end
                end
            end
            if (do_pop) begin
                m_data = q.pop_front();
                m_addr = m_wptr;
                m_active = 1'b1; m_load = 1'b1; m_need = HOLD;
            end
            if (push_req) begin
                if (old_size == DEPTH && !do_pop) m_ovf = 1'b1;
                else q.push_back(bus.sample_in);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("addr_out", bus.addr_out, m_addr);
            chk("data_out", bus.data_out, m_data);
            chk("rec_length", rec_length, m_len);
            chk("busy", busy, (m_active || q.size() != 0));
            chk("full", full, m_full);
            chk("overflow", overflow, m_ovf);
            chk("err_count", err_count, m_err);
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic pulse_start();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        bus.sample_in = v; bus.sample_valid = 1'b1; tick(); bus.sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        bus.sample_in = 16'd0; bus.sample_valid = 1'b0; bus.mem_status = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        chk_en = 1'b1;
        chk("reset_addr", bus.addr_out, 26'd0);
        chk("reset_len", rec_length, 26'd0);
        rec_enable = 1'b1;
        pulse_start();

        // Single sample: visible one cycle after push, commit 17 cycles after pop.
        bus.mem_status = 1'b1;
        push(16'hA5A5);
        tick();
        chk("t1_addr", bus.addr_out, 26'd0);
        chk("t1_data", bus.data_out, 16'hA5A5);
        repeat (16) tick();
        chk("t1_len_early", rec_length, 26'd0);
        chk("t1_busy_early", busy, 1'b1);
        tick();
        chk("t1_len", rec_length, 26'd1);
        chk("t1_busy_done", busy, 1'b0);
        chk("t1_model_len", m_len, 26'd1);

        // Burst of 10: 9 accepted, the 10th overflows.
        pulse_start();
        for (int i = 1; i <= 10; i++) push(16'(i));
        chk("t2_ovf", overflow, 1'b1);
        wait_idle(400);
        chk("t2_len", rec_length, 26'd9);
        chk("t2_last_addr", bus.addr_out, 26'd8);
        chk("t2_last_data", bus.data_out, 16'd9);

        // Status stall of 5 cycles delays commit by exactly 5.
        pulse_start();
        push(16'h1234);
        tick(); tick();
        repeat (5) tick();
        bus.mem_status = 1'b0;
        repeat (5) tick();
        bus.mem_status = 1'b1;
        repeat (10) tick();
        chk("t3_len_early", rec_length, 26'd0);
        chk("t3_addr", bus.addr_out, 26'd0);
        chk("t3_data", bus.data_out, 16'h1234);
        tick();
        chk("t3_len", rec_length, 26'd1);

        // Boundary: 16 slow samples, only addresses 0..MAXA written.
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            push(16'h4000 + 16'(i));
            repeat (20) tick();
        end
        chk("t4_full", full, 1'b1);
        chk("t4_len", rec_length, 26'd13);
        chk("t4_ovf", overflow, 1'b0);
        chk("t4_addr", bus.addr_out, 26'd12);

        // Reset mid-HOLD abandons the sample.
        pulse_start();
        push(16'h7777);
        tick();
        repeat (8) tick();
        reset = 1'b0;
        tick();
        chk("t5_addr", bus.addr_out, 26'd0);
        chk("t5_data", bus.data_out, 16'd0);
        chk("t5_len", rec_length, 26'd0);
        chk("t5_busy", busy, 1'b0);
        reset = 1'b1;
        pulse_start();
        push(16'hBEEF);
        tick();
        chk("t5_restart_addr", bus.addr_out, 26'd0);
        chk("t5_restart_data", bus.data_out, 16'hBEEF);
        wait_idle(100);

        // Readback verify: 3 corrupted commits then one clean.
        pulse_start();
        rb_flip = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(16'h0F00 + 16'(i));
            wait_idle(100);
        end
        rb_flip = 1'b0;
        push(16'h0F10);
        wait_idle(100);
`ifdef AUDIO_SEQ_READBACK_VERIFY_EN
        chk("t6_err", err_count, 8'd3);
`else
        chk("t6_err", err_count, 8'd0);
`endif
        pulse_start();
        chk("t6_err_clr", err_count, 8'd0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            bus.sample_in    = 16'($urandom);
            bus.sample_valid = ($urandom_range(0, 7) == 0);
            bus.mem_status   = ($urandom_range(0, 4) != 0);
            rec_enable       = ($urandom_range(0, 19) != 0);
            rb_flip          = ($urandom_range(0, 3) == 0);
            rec_start        = ($urandom_range(0, 599) == 0);
            reset            = ($urandom_range(0, 1499) != 0);
            tick();
        end
        reset = 1'b1; rec_start = 1'b0; bus.sample_valid = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
